// File: rtl/rf_arbiter_if.sv
// Per-master command/response bundle between a requester and rf_arbiter.
interface rf_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rf_arbiter.sv
// Two-master round-robin arbiter in front of a 1W/1R register file.
// Accept -> issue to the register file -> registered read response.
module rf_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rstn,
  rf_arbiter_if.slave       req0,
  rf_arbiter_if.slave       req1,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wren,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data
);

  typedef enum logic {MST0 = 1'b0, MST1 = 1'b1} mst_e;

  mst_e              last_gnt;
  mst_e              iss_owner;
  logic              iss_rd;
  logic              gnt0, gnt1, accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;

  // Grants are gated by rstn so ready stays low while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn) begin
      if (req0.valid && (!req1.valid || last_gnt == MST1))
        gnt0 = 1'b1;
      else if (req1.valid)
        gnt1 = 1'b1;
    end
  end

  assign accept    = gnt0 | gnt1;
  assign sel_we    = gnt1 ? req1.we    : req0.we;
  assign sel_addr  = gnt1 ? req1.addr  : req0.addr;
  assign sel_wdata = gnt1 ? req1.wdata : req0.wdata;

  assign req0.ready     = gnt0;
  assign req1.ready     = gnt1;
  assign req0.rsp_valid = rsp0_valid;
  assign req0.rsp_rdata = rsp0_rdata;
  assign req1.rsp_valid = rsp1_valid;
  assign req1.rsp_rdata = rsp1_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt   <= MST1;
      iss_owner  <= MST0;
      iss_rd     <= 1'b0;
      rf_wren    <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      rf_rd_addr <= '0;
    end else begin
      rf_wren <= accept && sel_we;
      iss_rd  <= accept && !sel_we;
      if (accept) begin
        last_gnt  <= gnt1 ? MST1 : MST0;
        iss_owner <= gnt1 ? MST1 : MST0;
        if (sel_we) begin
          rf_wr_addr <= sel_addr;
          rf_wr_data <= sel_wdata;
        end else begin
          rf_rd_addr <= sel_addr;
        end
      end
    end
  end

  // Read data is sampled at the end of the issue cycle; rdata holds between pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= iss_rd && (iss_owner == MST0);
      rsp1_valid <= iss_rd && (iss_owner == MST1);
      if (iss_rd && iss_owner == MST0) rsp0_rdata <= rf_rd_data;
      if (iss_rd && iss_owner == MST1) rsp1_rdata <= rf_rd_data;
    end
  end

endmodule

// File: tb/tb_rf_arbiter.sv
// Directed, table-driven bench for rf_arbiter with a behavioural 4x8 register file.
module tb_rf_arbiter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] rf_wr_addr, rf_rd_addr;
  logic [7:0] rf_wr_data, rf_rd_data;
  logic       rf_wren;
  logic [7:0] regs [4];

  int n_cmp = 0;
  int n_bad = 0;

  rf_arbiter_if #(.DATA_W(8), .ADDR_W(2)) m0 ();
  rf_arbiter_if #(.DATA_W(8), .ADDR_W(2)) m1 ();

  rf_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0       (m0),
    .req1       (m1),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .rf_wren    (rf_wren),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (rf_wren) begin
      regs[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_rd_data = regs[rf_rd_addr];

  typedef struct {
    logic       v0, we0; logic [1:0] a0; logic [7:0] d0;
    logic       v1, we1; logic [1:0] a1; logic [7:0] d1;
    logic       r0, r1, wren; logic [1:0] wa; logic [7:0] wd; logic [1:0] ra;
    logic       rv0; logic [7:0] rd0; logic rv1; logic [7:0] rd1;
  } vec_t;

  vec_t vec [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, we0, input logic [1:0] a0, input logic [7:0] d0,
                       input logic v1, we1, input logic [1:0] a1, input logic [7:0] d1);
    m0.valid = v0; m0.we = we0; m0.addr = a0; m0.wdata = d0;
    m1.valid = v1; m1.we = we1; m1.addr = a1; m1.wdata = d1;
  endtask

  initial begin
    //          v0 we a0 d0     v1 we a1 d1     r0 r1 wr wa wd     ra rv0 rd0    rv1 rd1
    vec[0]  = '{1, 1, 0, 8'h10, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00};
    vec[1]  = '{1, 1, 1, 8'h11, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h10, 0, 0, 8'h00, 0, 8'h00};
    vec[2]  = '{1, 1, 2, 8'h12, 0, 0, 0, 8'h00, 1, 0, 1, 1, 8'h11, 0, 0, 8'h00, 0, 8'h00};
    vec[3]  = '{1, 1, 3, 8'h13, 0, 0, 0, 8'h00, 1, 0, 1, 2, 8'h12, 0, 0, 8'h00, 0, 8'h00};
    vec[4]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 3, 8'h13, 0, 0, 8'h00, 0, 8'h00};
    vec[5]  = '{1, 0, 2, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 3, 8'h13, 0, 0, 8'h00, 0, 8'h00};
    vec[6]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 3, 8'h13, 2, 0, 8'h00, 0, 8'h00};
    vec[7]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 3, 8'h13, 2, 1, 8'h12, 0, 8'h00};
    vec[8]  = '{1, 0, 1, 8'h00, 1, 0, 3, 8'h00, 0, 1, 0, 3, 8'h13, 2, 0, 8'h12, 0, 8'h00};
    vec[9]  = '{1, 0, 1, 8'h00, 1, 0, 3, 8'h00, 1, 0, 0, 3, 8'h13, 3, 0, 8'h12, 0, 8'h00};
    vec[10] = '{1, 0, 1, 8'h00, 1, 0, 3, 8'h00, 0, 1, 0, 3, 8'h13, 1, 0, 8'h12, 1, 8'h13};
    vec[11] = '{1, 0, 1, 8'h00, 1, 0, 3, 8'h00, 1, 0, 0, 3, 8'h13, 3, 1, 8'h11, 0, 8'h13};
    vec[12] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 3, 8'h13, 1, 0, 8'h11, 1, 8'h13};
    vec[13] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 3, 8'h13, 1, 1, 8'h11, 0, 8'h13};
    vec[14] = '{1, 1, 1, 8'hA5, 0, 0, 0, 8'h00, 1, 0, 0, 3, 8'h13, 1, 0, 8'h11, 0, 8'h13};
    vec[15] = '{0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 1, 1, 1, 8'hA5, 1, 0, 8'h11, 0, 8'h13};
    vec[16] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 0, 8'h11, 0, 8'h13};
    vec[17] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 0, 8'h11, 1, 8'hA5};
    vec[18] = '{1, 1, 0, 8'h55, 1, 1, 0, 8'hAA, 1, 0, 0, 1, 8'hA5, 1, 0, 8'h11, 0, 8'hA5};
    vec[19] = '{0, 0, 0, 8'h00, 1, 1, 0, 8'hAA, 0, 1, 1, 0, 8'h55, 1, 0, 8'h11, 0, 8'hA5};
    vec[20] = '{1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'hAA, 1, 0, 8'h11, 0, 8'hA5};
    vec[21] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hAA, 0, 0, 8'h11, 0, 8'hA5};
    vec[22] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hAA, 0, 1, 8'hAA, 0, 8'hA5};

    // Reset held with both masters requesting: everything must stay at zero.
    drive(1, 0, 0, 8'h00, 1, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    chk("rst ready0", m0.ready, 0);
    chk("rst ready1", m1.ready, 0);
    chk("rst wren", rf_wren, 0);
    chk("rst wr_addr", rf_wr_addr, 0);
    chk("rst wr_data", rf_wr_data, 0);
    chk("rst rd_addr", rf_rd_addr, 0);
    chk("rst rsp0_valid", m0.rsp_valid, 0);
    chk("rst rsp0_rdata", m0.rsp_rdata, 0);
    chk("rst rsp1_valid", m1.rsp_valid, 0);
    chk("rst rsp1_rdata", m1.rsp_rdata, 0);

    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("release ready0", m0.ready, 1);
    chk("release ready1", m1.ready, 0);
    // Re-enter reset before the edge so the table starts from a clean state.
    rstn = 1'b0;
    drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vec[i].v0, vec[i].we0, vec[i].a0, vec[i].d0,
            vec[i].v1, vec[i].we1, vec[i].a1, vec[i].d1);
      #1;
      chk($sformatf("row%0d ready0", i), m0.ready, vec[i].r0);
      chk($sformatf("row%0d ready1", i), m1.ready, vec[i].r1);
      chk($sformatf("row%0d wren", i), rf_wren, vec[i].wren);
      chk($sformatf("row%0d wr_addr", i), rf_wr_addr, vec[i].wa);
      chk($sformatf("row%0d wr_data", i), rf_wr_data, vec[i].wd);
      chk($sformatf("row%0d rd_addr", i), rf_rd_addr, vec[i].ra);
      chk($sformatf("row%0d rsp0_valid", i), m0.rsp_valid, vec[i].rv0);
      chk($sformatf("row%0d rsp0_rdata", i), m0.rsp_rdata, vec[i].rd0);
      chk($sformatf("row%0d rsp1_valid", i), m1.rsp_valid, vec[i].rv1);
      chk($sformatf("row%0d rsp1_rdata", i), m1.rsp_rdata, vec[i].rd1);
    end

    chk("final reg0", regs[0], 8'hAA);
    chk("final reg1", regs[1], 8'hA5);

    // Reset while a master-1 read sits in the issue stage: its response is dropped.
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 1, 0, 2, 8'h00);
    #1;
    chk("midrst ready1", m1.ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    rstn = 1'b0;
    #1;
    chk("midrst rsp1_valid", m1.rsp_valid, 0);
    chk("midrst rsp1_rdata", m1.rsp_rdata, 0);
    chk("midrst rd_addr", rf_rd_addr, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("midrst hold%0d rsp1_valid", c), m1.rsp_valid, 0);
    end

    @(negedge clk);
    rstn = 1'b1;
    drive(1, 0, 2, 8'h00, 1, 0, 2, 8'h00);
    #1;
    chk("post ready0", m0.ready, 1);
    chk("post ready1", m1.ready, 0);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    #1;
    chk("post rsp1_valid c0", m1.rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("post rsp0_valid", m0.rsp_valid, 1);
    chk("post rsp1_valid c1", m1.rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("post rsp0_pulse_end", m0.rsp_valid, 0);
    chk("post rsp1_valid c2", m1.rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
- Two-requester round-robin arbiter that shares the 4x8 register file (1 write port, 1 combinational read port) between two independent masters.
- Each master issues read or write commands over a valid/ready handshake. The arbiter serialises them into register-file port activity and returns read data on a per-master response strobe.
- Sits directly in front of the register file; the register file's ports are driven only by this block.

Parameters:
DATA_W, 8, register data width
ADDR_W, 2, register address width (2**ADDR_W registers)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req0_valid  in  1  master 0 command valid
req0_ready  out  1  master 0 command accepted this cycle
req0_we  in  1  master 0: 1 = write, 0 = read
req0_addr  in  ADDR_W  master 0 register address
req0_wdata  in  DATA_W  master 0 write data
rsp0_valid  out  1  master 0 read data valid (single-cycle pulse)
rsp0_rdata  out  DATA_W  master 0 read data
req1_valid  in  1  master 1 command valid
req1_ready  out  1  master 1 command accepted this cycle
req1_we  in  1  master 1: 1 = write, 0 = read
req1_addr  in  ADDR_W  master 1 register address
req1_wdata  in  DATA_W  master 1 write data
rsp1_valid  out  1  master 1 read data valid (single-cycle pulse)
rsp1_rdata  out  DATA_W  master 1 read data
rf_wr_addr  out  ADDR_W  register file write address
rf_wr_data  out  DATA_W  register file write data
rf_wren  out  1  register file write enable
rf_rd_addr  out  ADDR_W  register file read address
rf_rd_data  in  DATA_W  register file read data (combinational from rf_rd_addr)

Behaviour:
- Reset: clk is the clock; rstn is asynchronous, active-low.
  - Reset values: req*_ready=0, rsp*_valid=0, rsp*_rdata=0, rf_wren=0, rf_wr_addr=0, rf_wr_data=0, rf_rd_addr=0.
  - Round-robin pointer last_gnt=1, so master 0 wins the first contention.
- Grant (combinational):
  - Only one valid: that master is granted.
  - Both valid: the master not equal to last_gnt is granted.
  - Neither valid: no grant.
  - reqK_ready = grant_K. At most one ready high per cycle.
  - ready never asserts without the matching valid.
- Handshake: a command is accepted on the rising edge where valid && ready.
  - A master holding valid without ready keeps we/addr/wdata stable.
  - The arbiter does not latch unaccepted commands.
- Pointer: last_gnt updates to the granted master only on an accepted handshake. It is unchanged on idle cycles.
- Issue stage (registered, 1 cycle): a command accepted at edge T drives the register file during cycle T+1.
  - Write: rf_wren=1, rf_wr_addr/rf_wr_data = command fields. The register file commits at edge T+1.
  - Read: rf_rd_addr = command addr, rf_wren=0. The issue-stage owner ID and read flag are registered.
  - Idle issue cycle: rf_wren=0, rf_wr_addr/rf_wr_data/rf_rd_addr hold their last values.
- Response (registered): for a read issued in cycle T+1, rf_rd_data is sampled at edge T+1.
  - rspK_valid=1 and rspK_rdata = sampled data during cycle T+2, where K = owner. The other master's rsp_valid stays 0.
  - rspK_valid is a one-cycle pulse. rspK_rdata holds its last value while rspK_valid=0.
  - No response backpressure: the master must take data the cycle it is presented.
- Latency:
  - Read: handshake edge to rsp_valid = 2 cycles.
  - Write: handshake edge to register update = 1 cycle later edge.
  - Throughput: 1 command per cycle total across both masters.
- Ordering and hazards: commands reach the register file strictly in acceptance order.
  - A read accepted one cycle after a write to the same address returns the new data: the write commits at the edge that issues the read, so no forwarding is needed.
  - Same-address writes from both masters: both execute, serialised in grant order, last accepted wins.
- Fairness: with both valid continuously, grants alternate 0,1,0,1,…; neither master waits more than 1 cycle.
- Reset mid-operation: any issued-but-not-responded read is dropped (no rsp pulse after reset release). The pointer returns to last_gnt=1.

Test Plan:
- Reset: hold rstn=0 with both valid=1 -> all outputs 0, ready both 0; first cycle after release -> req0_ready=1, req1_ready=0.
- Master 0 writes addr 0..3 with data 0x10..0x13 back-to-back, master 1 idle -> rf_wren=1 for 4 consecutive cycles, each 1 cycle after its handshake, addr/data matching; then master 0 reads addr 2 -> rsp0_valid pulse 2 cycles after handshake with rdata 0x13? no: rdata 0x12.
- Both masters continuously valid: m0 reads addr 1, m1 reads addr 3 (values 0x11/0x13) -> grants alternate 0,1,0,1; rsp0 returns 0x11 and rsp1 returns 0x13 on alternating cycles; rsp1_valid is never high while rsp0_valid is high.
- Write-then-read hazard: m0 writes 0xA5 to addr 1 at edge T, m1 reads addr 1 accepted at edge T+1 -> rsp1_rdata=0xA5 at cycle T+3.
- Same-address contention: both write addr 0 in the same cycle (m0 0x55, m1 0xAA), last_gnt=1 -> m0 first, m1 second; subsequent read of addr 0 returns 0xAA.
- Reset mid-read: accept m1 read, assert rstn=0 the following cycle -> rsp1_valid never pulses; after release, arbitration restarts with master 0 priority.
